// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shadow-entry layout {valid, wb_en, mem_read, dest} and default widths
package pipe_hazard_ctrl_pkg;
  localparam int REG_ADDR_W_DEF = 4;
  localparam int ENT_FLAGS = 3;
  function automatic int ent_w(input int aw);
    return aw + ENT_FLAGS;
  endfunction
  function automatic int off_mem_read(input int aw);
    return aw;
  endfunction
  function automatic int off_wb_en(input int aw);
    return aw + 1;
  endfunction
  function automatic int off_valid(input int aw);
    return aw + 2;
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_slot_cmp.sv
// pipe_hazard_ctrl_slot_cmp: RAW / load-use compare of one shadow slot against the ID operands
module pipe_hazard_ctrl_slot_cmp
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int AW = REG_ADDR_W_DEF,
  parameter bit EN = 1'b1,
  parameter bit LOAD_ONLY = 1'b0
) (
  input  logic [ent_w(AW)-1:0] ent,
  input  logic [AW-1:0]        src1,
  input  logic [AW-1:0]        src2,
  input  logic                 two_src,
  output logic                 hit
);
  logic m;
  // slot hits when it will write a register the ID instruction reads
  always_comb begin
    m = ent[off_valid(AW)] & ent[off_wb_en(AW)] &
        ((ent[AW-1:0] == src1) | (two_src & (ent[AW-1:0] == src2)));
    hit = EN & m & (~LOAD_ONLY | ent[off_mem_read(AW)]);
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: IF/ID freeze/flush from a shadow write scoreboard; PIPE_FORWARDING_EN limits stalls to load-use
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic                  id_wb_en,
  input  logic                  id_mem_read,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  branch_taken,
  output logic                  freeze,
  output logic                  flush,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  localparam int EW = ent_w(REG_ADDR_W);
`ifdef PIPE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic [EW-1:0] sh [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] hit;
  logic [EW-1:0] id_ent;
  logic hazard;
  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_cmp
    pipe_hazard_ctrl_slot_cmp #(
      .AW(REG_ADDR_W),
      .EN(!FWD || k == 0),
      .LOAD_ONLY(FWD)
    ) u_cmp (
      .ent(sh[k]),
      .src1(id_src1),
      .src2(id_src2),
      .two_src(id_two_src),
      .hit(hit[k])
    );
  end
  // flush beats freeze; both forced low while reset is asserted
  always_comb begin
    hazard = id_valid & (|hit);
    flush = branch_taken & ~rst;
    freeze = hazard & ~branch_taken & ~rst;
    id_ent = (freeze | flush | ~id_valid) ? '0 : {1'b1, id_wb_en, id_mem_read, id_dest};
  end
  // shadow pipeline: slot 0 = EXE ... slot PIPE_DEPTH-1 = WB, bubbles enter while held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) sh[i] <= '0;
    end else begin
      sh[0] <= id_ent;
      for (int i = 1; i < PIPE_DEPTH; i++) sh[i] <= sh[i-1];
    end
  end
  // saturating debug event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (freeze && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule
